// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte sources.
// Round-robin pick from rr_ptr, with a packet lock: the owner keeps the TX
// until it sends a byte flagged last. Each byte goes out as a one-cycle
// transmit pulse and is paced by busy_tx.
// Optional feature: define TX_TIMEOUT_EN to abort a packet that stays in
// START or BUSY for TIMEOUT_CYC cycles (err_timeout pulse, grant dropped).
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               transmit,
  output logic [7:0]         data_tx,
  input  logic               busy_tx,
  output logic               err_timeout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, START, BUSY} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]       data_tx_d;
  logic             last_q, last_d;
  logic             transmit_d;
  logic             err_d;

  logic [PW-1:0]    owner;
  logic [PW-1:0]    owner_next;
  logic             owner_valid;
  logic             owner_last;
  logic [7:0]       owner_byte;
  logic [PW-1:0]    winner;
  logic             win_found;
  logic             tmo_hit;

  // Only the current owner is ever offered ready, and only while loading.
  assign req_ready  = grant & {N_REQ{state_q == LOAD}};
  assign owner_next = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // Decode the owner index and its request signals from the one-hot grant.
  always_comb begin
    owner       = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_byte  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        owner       = PW'(i);
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_byte  = req_data[8*i +: 8];
      end
    end
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [PW:0] sum;
    sum       = '0;
    winner    = '0;
    win_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      if (!win_found && req_valid[sum[PW-1:0]]) begin
        win_found = 1'b1;
        winner    = sum[PW-1:0];
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == CW'(TIMEOUT_CYC - 1));

  // Cycle counter for START/BUSY; restarts on every state change.
  always_comb begin
    tmo_d = '0;
    if ((state_q == START || state_q == BUSY) && state_d == state_q)
      tmo_d = tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and next-output logic of the arbiter FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in combinational logic infers a latch.
    state_d    = state_q;
    grant_d    = grant;
    rr_ptr_d   = rr_ptr_q;
    data_tx_d  = data_tx;
    last_d     = last_q;
    transmit_d = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!busy_tx && win_found) begin
          grant_d = N_REQ'(1) << winner;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (owner_valid) begin
          data_tx_d  = owner_byte;
          last_d     = owner_last;
          transmit_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        if (busy_tx) begin
          state_d = BUSY;
        end else if (tmo_hit) begin
          err_d    = 1'b1;
          grant_d  = '0;
          rr_ptr_d = owner_next;
          state_d  = IDLE;
        end
      end
      BUSY: begin
        if (!busy_tx) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = owner_next;
            state_d  = IDLE;
          end else begin
            state_d = LOAD;
          end
        end else if (tmo_hit) begin
          err_d    = 1'b1;
          grant_d  = '0;
          rr_ptr_d = owner_next;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      grant       <= '0;
      rr_ptr_q    <= '0;
      data_tx     <= '0;
      last_q      <= 1'b0;
      transmit    <= 1'b0;
      err_timeout <= 1'b0;
`ifdef TX_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      data_tx     <= data_tx_d;
      last_q      <= last_d;
      transmit    <= transmit_d;
      err_timeout <= err_d;
`ifdef TX_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester queues drive the inputs, a UART
// model answers transmit with busy_tx, and a monitor compares every transmit
// pulse against a scoreboard of expected (source, byte) pairs.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 20;

  typedef struct {
    int         src;
    logic [7:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           transmit;
  logic [7:0]     data_tx;
  logic           busy_tx;
  logic           err_timeout;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;

  logic [8:0] req_q [N][$];
  exp_t       exp_q [$];
  logic [N-1:0] acc_q = '0;
  int   busy_cnt = 0;
  logic stuck = 1'b0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .transmit(transmit), .data_tx(data_tx), .busy_tx(busy_tx),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int src, input logic [7:0] b, input logic last);
    exp_t e;
    e.src  = src;
    e.data = b;
    req_q[src].push_back({last, b});
    exp_q.push_back(e);
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (req_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (n < 600 && !(exp_q.size() == 0 && grant == '0 && queues_empty())) begin
      tick();
      n++;
    end
    check(name, 32'(n < 600), 32'd1);
  endtask

  // UART model: busy for 10 cycles starting the cycle after transmit.
  always @(posedge clk) begin
    if (transmit && !stuck) busy_cnt <= 10;
    else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
  end
  assign busy_tx = (busy_cnt != 0);

  // Record accepted bytes at the active edge.
  always @(posedge clk) acc_q <= req_valid & req_ready;

  // Requester driver: pop accepted bytes, present the next queue head.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic [8:0] head;
      if (acc_q[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
      if (req_q[i].size() > 0) begin
        head = req_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = head[7:0];
        req_last[i]        = head[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  // Monitor: every transmit pulse must match the next expected entry.
  always @(negedge clk) begin
    if (err_timeout) err_cnt++;
    if (!rst && transmit) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra_tx: got byte 0x%0h grant 0x%0h, expected no transmit", data_tx, grant);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_data", 32'(data_tx), 32'(e.data));
        check("sb_grant", 32'(grant), 32'(1 << e.src));
      end
    end
  end

  initial begin
    int n;
    int bad;
    int seen;

    // Reset values
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_transmit", 32'(transmit), 32'd0);
    check("rst_data_tx", 32'(data_tx), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single byte latency and grant release
    send(0, 8'h35, 1'b1);
    tick();
    check("t1_grant", 32'(grant), 32'h1);
    check("t1_ready", 32'(req_ready), 32'h1);
    check("t1_no_tx_yet", 32'(transmit), 32'd0);
    tick();
    check("t1_transmit", 32'(transmit), 32'd1);
    check("t1_data", 32'(data_tx), 32'h35);
    check("t1_ready_low", 32'(req_ready), 32'd0);
    tick();
    check("t1_pulse_one", 32'(transmit), 32'd0);
    n = 0;
    while (n < 40 && grant != '0) begin tick(); n++; end
    check("t1_grant_released", 32'(grant), 32'd0);
    check("t1_busy_low_at_release", 32'(busy_tx), 32'd0);
    check("t1_data_held", 32'(data_tx), 32'h35);

    // 2: req0 and req2 together from reset, then req0 again after wrap
    rst = 1'b1; tick(); rst = 1'b0;
    send(0, 8'hA0, 1'b1);
    send(2, 8'hA2, 1'b1);
    send(0, 8'hA1, 1'b1);
    wait_idle("t2_done");

    // 3: three-byte packet from req1 while req3 waits
    rst = 1'b1; tick(); rst = 1'b0;
    send(1, 8'h01, 1'b0);
    send(1, 8'h02, 1'b0);
    send(1, 8'h03, 1'b1);
    send(3, 8'h33, 1'b1);
    bad = 0; seen = 0; n = 0;
    while (n < 200 && grant != 4'h8) begin
      tick(); n++;
      if (grant == 4'h2) seen++;
      if (grant == 4'h2 && req_ready[3]) bad++;
    end
    check("t3_req3_held_off", 32'(bad), 32'd0);
    check("t3_req1_owned", 32'(seen > 30), 32'd1);
    wait_idle("t3_done");

    // 4: reset while a byte is in flight
    send(2, 8'h42, 1'b1);
    send(2, 8'h44, 1'b1);
    n = 0;
    while (n < 200 && !(exp_q.size() == 0 && busy_tx && grant == 4'h4)) begin tick(); n++; end
    check("t4_reached_busy", 32'(n < 200), 32'd1);
    tick();
    send(3, 8'h31, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_grant", 32'(grant), 32'd0);
    check("t4_rst_transmit", 32'(transmit), 32'd0);
    check("t4_rst_data", 32'(data_tx), 32'd0);
    check("t4_rst_ready", 32'(req_ready), 32'd0);
    check("t4_busy_still", 32'(busy_tx), 32'd1);
    send(1, 8'h11, 1'b1);
    // Reorder so req1 is expected first: rr_ptr restarts at 0 after reset.
    begin
      exp_t a, b;
      a = exp_q.pop_front();
      b = exp_q.pop_front();
      exp_q.push_back(b);
      exp_q.push_back(a);
    end
    bad = 0; n = 0;
    while (n < 40 && busy_tx) begin
      if (grant != '0) bad++;
      tick(); n++;
    end
    check("t4_no_grant_while_busy", 32'(bad), 32'd0);
    wait_idle("t4_done");

    // 5: owner lock across a long valid gap
    send(0, 8'h51, 1'b0);
    send(1, 8'h61, 1'b1);
    bad = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (c >= 20 && (grant != 4'h1 || req_ready != 4'h1)) bad++;
    end
    check("t5_lock_held", 32'(bad), 32'd0);
    check("t5_req1_waiting", 32'(exp_q.size()), 32'd1);
    send(0, 8'h52, 1'b1);
    begin
      exp_t a, b;
      a = exp_q.pop_front();
      b = exp_q.pop_front();
      exp_q.push_back(b);
      exp_q.push_back(a);
    end
    wait_idle("t5_done");

`ifdef TX_TIMEOUT_EN
    // 6: busy_tx stuck low after transmit -> abort at cycle TMO of START
    stuck = 1'b1;
    send(2, 8'h66, 1'b1);
    n = 0;
    while (n < 50 && !transmit) begin tick(); n++; end
    check("t6_transmit_seen", 32'(transmit), 32'd1);
    n = 0;
    while (n < 60 && !err_timeout) begin tick(); n++; end
    check("t6_err_cycle", 32'(n), 32'(TMO));
    check("t6_grant_dropped", 32'(grant), 32'd0);
    tick();
    check("t6_err_one_cycle", 32'(err_timeout), 32'd0);
    stuck = 1'b0;
    send(3, 8'h77, 1'b1);
    wait_idle("t6_done");
    check("t6_err_count", 32'(err_cnt), 32'd1);
`else
    check("err_never", 32'(err_cnt), 32'd0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
